wb_mailbox: RTL and testbench

WB_MAILBOX -- requirements
Module: wb_mailbox

---
 rtl/wb_mailbox_pkg.sv | 25 ++
 rtl/mailbox_fifo.sv | 47 ++++
 rtl/wb_mailbox.sv | 161 ++++++++++++++++
 tb/tb_wb_mailbox.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/wb_mailbox_pkg.sv
// Shared definitions for the Wishbone mailbox: register offsets, bit positions
// and the protocol state encoding.
package wb_mailbox_pkg;

  // Word offsets (wb_adr_i[5:2])
  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h1;
  localparam logic [3:0] REG_CTRL   = 4'h2;
  localparam logic [3:0] REG_THRESH = 4'h3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_UNF       = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous word FIFO with flush; storage is deliberately left unreset.
module mailbox_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_mailbox.sv
// Wishbone classic slave mailbox: a 32-bit FIFO with status, control and
// threshold interrupt. Each access is sampled in IDLE and terminated in RESP.
module wb_mailbox
  import wb_mailbox_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [5:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        irq_o,
  output state_t      fsm_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state, state_next;
  logic          ack_d, err_d, push, pop, flush;
  logic          ovf_set, unf_set, ovf_clr, unf_clr;
  logic [31:0]   dat_d, status_word, head;
  logic          ovf, unf, irq_en, irq_en_d;
  logic [7:0]    thresh, thresh_d, count8;
  logic          full, empty;
  logic [CW-1:0] count;
  logic [3:0]    reg_sel;
  logic          unused_ok;

  assign wb_rty_o  = 1'b0;
  assign fsm_state = state;
  assign reg_sel   = wb_adr_i[5:2];
  assign count8    = 8'(count);
  assign unused_ok = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

  mailbox_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (wb_dat_i),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    status_word                        = '0;
    status_word[ST_EMPTY]              = empty;
    status_word[ST_FULL]               = full;
    status_word[ST_OVF]                = ovf;
    status_word[ST_UNF]                = unf;
    status_word[ST_COUNT_LSB +: 8]     = count8;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // All side effects are decoded only in IDLE, so each access acts exactly once.
  always_comb begin
    state_next = state;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = '0;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    ovf_clr    = 1'b0;
    unf_clr    = 1'b0;
    irq_en_d   = irq_en;
    thresh_d   = thresh;
    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_next = RESP;
          case (reg_sel)
            REG_DATA: begin
              if (wb_we_i) begin
                if (wb_sel_i != 4'hF) err_d = 1'b1;
                else begin
                  ack_d = 1'b1;
                  if (full) ovf_set = 1'b1;
                  else      push    = 1'b1;
                end
              end else begin
                ack_d = 1'b1;
                if (empty) unf_set = 1'b1;
                else begin
                  pop   = 1'b1;
                  dat_d = head;
                end
              end
            end
            REG_STATUS: begin
              ack_d = 1'b1;
              if (!wb_we_i) dat_d = status_word;
              else if (wb_sel_i[0]) begin
                ovf_clr = wb_dat_i[ST_OVF];
                unf_clr = wb_dat_i[ST_UNF];
              end
            end
            REG_CTRL: begin
              ack_d = 1'b1;
              if (!wb_we_i) dat_d = {31'b0, irq_en};
              else if (wb_sel_i[0]) begin
                irq_en_d = wb_dat_i[CTRL_IRQ_EN];
                flush    = wb_dat_i[CTRL_FLUSH];
              end
            end
            REG_THRESH: begin
              ack_d = 1'b1;
              if (!wb_we_i)         dat_d    = {24'b0, thresh};
              else if (wb_sel_i[0]) thresh_d = wb_dat_i[7:0];
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      irq_en   <= 1'b0;
      thresh   <= '0;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= ack_d;
      wb_err_o <= err_d;
      wb_dat_o <= dat_d;
      ovf      <= ovf_set | (ovf & ~ovf_clr);
      unf      <= unf_set | (unf & ~unf_clr);
      irq_en   <= irq_en_d;
      thresh   <= thresh_d;
      irq_o    <= irq_en & (count8 >= thresh) & (thresh != 8'd0);
    end
  end

endmodule

// File: tb/tb_wb_mailbox.sv
// Directed bench for wb_mailbox: register map, FIFO order, overflow/underflow,
// interrupt threshold, back-to-back strobes and reset during a response.
module tb_wb_mailbox;
  import wb_mailbox_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  adr = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat_r;
  logic        ack, err, rty, irq;
  state_t      fsm_state;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd;
  logic        a, e;

  wb_mailbox #(.DEPTH(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_w),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_cti_i  (cti),
    .wb_bte_i  (bte),
    .wb_dat_o  (dat_r),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .wb_rty_o  (rty),
    .irq_o     (irq),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  // One access: drive on a falling edge, sampled at the next rising edge,
  // termination observed on the following falling edge; cyc drops there.
  task automatic wb_access(input logic [5:0] a_adr, input logic [31:0] a_dat,
                           input logic [3:0] a_sel, input logic a_we,
                           output logic [31:0] o_dat, output logic o_ack,
                           output logic o_err);
    @(negedge clk);
    adr = a_adr; dat_w = a_dat; sel = a_sel; we = a_we;
    cti = 3'($urandom_range(0, 7)); bte = 2'($urandom_range(0, 3));
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_dat = dat_r; o_ack = ack; o_err = err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (dat_r !== 32'h0) begin errors++; $display("FAIL reset_dat got=%h exp=0", dat_r); end
    checks++; if (rty !== 1'b0) begin errors++; $display("FAIL reset_rty got=%b exp=0", rty); end
    rst = 1'b0;
    // Strobe held before sampling: no termination yet.
    @(negedge clk);
    adr = 6'h04; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL pre_sample_ack got=%b exp=0", ack); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL status_ack got=%b exp=1", ack); end
    checks++; if (dat_r !== 32'h1) begin errors++; $display("FAIL status_after_reset got=%h exp=00000001", dat_r); end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_fifo_order();
    for (int i = 1; i <= 3; i++) begin
      wb_access(6'h00, 32'hA5A5_0000 + 32'(i), 4'hF, 1'b1, rd, a, e);
      checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL push_ack[%0d] got=%b/%b exp=1/0", i, a, e); end
    end
    wb_access(6'h04, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h0000_0300) begin errors++; $display("FAIL status_count3 got=%h exp=00000300", rd); end
    for (int i = 1; i <= 3; i++) begin
      wb_access(6'h00, 32'h0, 4'hF, 1'b0, rd, a, e);
      checks++; if (rd !== 32'hA5A5_0000 + 32'(i)) begin errors++; $display("FAIL pop[%0d] got=%h exp=%h", i, rd, 32'hA5A5_0000 + 32'(i)); end
    end
    wb_access(6'h04, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL status_count0 got=%h exp=00000001", rd); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) wb_access(6'h00, 32'(i), 4'hF, 1'b1, rd, a, e);
    checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL push17_ack got=%b/%b exp=1/0", a, e); end
    wb_access(6'h04, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h0000_1006) begin errors++; $display("FAIL status_full_ovf got=%h exp=00001006", rd); end
    wb_access(6'h04, 32'h4, 4'hF, 1'b1, rd, a, e);
    wb_access(6'h04, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h0000_1002) begin errors++; $display("FAIL status_ovf_w1c got=%h exp=00001002", rd); end
    wb_access(6'h00, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL pop_after_wrap got=%h exp=00000000", rd); end
    wb_access(6'h08, 32'h2, 4'hF, 1'b1, rd, a, e);
    wb_access(6'h04, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL status_after_flush got=%h exp=00000001", rd); end
  endtask

  task automatic test_underflow_err();
    wb_access(6'h00, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h0 || a !== 1'b1) begin errors++; $display("FAIL pop_empty got=%h ack=%b exp=0 ack=1", rd, a); end
    wb_access(6'h04, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h0000_0009) begin errors++; $display("FAIL status_unf got=%h exp=00000009", rd); end
    wb_access(6'h20, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (e !== 1'b1 || a !== 1'b0) begin errors++; $display("FAIL bad_offset err/ack got=%b/%b exp=1/0", e, a); end
    wb_access(6'h04, 32'h8, 4'hF, 1'b1, rd, a, e);
    wb_access(6'h00, 32'h1234_5678, 4'h3, 1'b1, rd, a, e);
    checks++; if (e !== 1'b1 || a !== 1'b0) begin errors++; $display("FAIL partial_push err/ack got=%b/%b exp=1/0", e, a); end
    wb_access(6'h04, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL status_after_err got=%h exp=00000001", rd); end
  endtask

  task automatic test_irq();
    wb_access(6'h0C, 32'h2, 4'hF, 1'b1, rd, a, e);
    wb_access(6'h08, 32'h1, 4'hF, 1'b1, rd, a, e);
    wb_access(6'h00, 32'hC0DE_0001, 4'hF, 1'b1, rd, a, e);
    wb_access(6'h00, 32'hC0DE_0002, 4'hF, 1'b1, rd, a, e);
    @(posedge clk); @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_thresh got=%b exp=1", irq); end
    wb_access(6'h00, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_same_cycle_pop got=%b exp=1", irq); end
    @(posedge clk); @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_below_thresh got=%b exp=0", irq); end
    wb_access(6'h0C, 32'hFFFF_FF05, 4'b0010, 1'b1, rd, a, e);
    wb_access(6'h0C, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL thresh_sel_masked got=%h exp=00000002", rd); end
    wb_access(6'h0C, 32'hFFFF_FF03, 4'b0001, 1'b1, rd, a, e);
    wb_access(6'h0C, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL thresh_sel_byte0 got=%h exp=00000003", rd); end
    wb_access(6'h08, 32'h3, 4'hF, 1'b1, rd, a, e);
    wb_access(6'h08, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ctrl_read got=%h exp=00000001", rd); end
    wb_access(6'h04, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL status_irq_flush got=%h exp=00000001", rd); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    adr = 6'h00; dat_w = 32'hB0B0_0001; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got=%b exp=1", ack); end
    dat_w = 32'hB0B0_0002;
    @(posedge clk); @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%b exp=0", ack); end
    @(posedge clk); @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got=%b exp=1", ack); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wb_access(6'h04, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h0000_0200) begin errors++; $display("FAIL b2b_count got=%h exp=00000200", rd); end
    wb_access(6'h00, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'hB0B0_0001) begin errors++; $display("FAIL b2b_pop1 got=%h exp=b0b00001", rd); end
    wb_access(6'h00, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'hB0B0_0002) begin errors++; $display("FAIL b2b_pop2 got=%h exp=b0b00002", rd); end
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk);
    adr = 6'h00; dat_w = 32'hDEAD_0001; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (ack !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_resp_term got=%b/%b exp=0/0", ack, err); end
    checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL rst_resp_state got=%0d exp=0", fsm_state); end
    rst = 1'b0;
    wb_access(6'h04, 32'h0, 4'hF, 1'b0, rd, a, e);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL rst_resp_status got=%h exp=00000001", rd); end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow();
    test_underflow_err();
    test_irq();
    test_back_to_back();
    test_reset_in_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
